// File: rtl/fp_pkg.sv
// Shared types and helpers for the floating-point datapath: operand classes,
// exception flag bit positions, divider FSM states and constant generators.
package fp_pkg;

  // Operand classes. Subnormals are folded into ZERO (denormals-are-zero).
  typedef enum logic [2:0] {
    ZERO   = 3'd0,
    NORMAL = 3'd1,
    INF    = 3'd2,
    QNAN   = 3'd3,
    SNAN   = 3'd4
  } fp_class_e;

  // Bit positions inside the 5-bit flag vector {invalid, dz, of, uf, nx}.
  localparam int FLAG_INVALID   = 4;
  localparam int FLAG_DIV_ZERO  = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  // Divider sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } fdiv_state_e;

  // Exponent bias for an EXP_W-bit exponent field.
  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN (sign 0, exponent all ones, mantissa MSB only),
  // returned in a wide vector; callers truncate to their operand width.
  function automatic logic [127:0] qnan(input int exp_w, input int man_w);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < exp_w; i++) begin
      v[man_w + i] = 1'b1;
    end
    v[man_w - 1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Classifies the magnitude part (exponent + mantissa) of an IEEE-754 operand.
// Subnormal encodings report ZERO so the divider treats them as signed zero.
module fp_classify
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W-1:0] mag,
  output fp_class_e              cls
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;

  assign exp_f = mag[EXP_W+MAN_W-1:MAN_W];
  assign man_f = mag[MAN_W-1:0];

  // Decode exponent/mantissa patterns into an operand class.
  always_comb begin
    cls = NORMAL;
    if (exp_f == '0) begin
      cls = ZERO;
    end else if (&exp_f) begin
      if (man_f == '0) begin
        cls = INF;
      end else if (man_f[MAN_W-1]) begin
        cls = QNAN;
      end else begin
        cls = SNAN;
      end
    end
  end

endmodule

// File: rtl/fdiv_seq.sv
// Multi-cycle IEEE-754 divider: radix-2 restoring mantissa division producing
// one quotient bit per cycle, round-to-nearest-even, DAZ/FTZ, full special
// case handling and a {nv, dz, of, uf, nx} flag vector. One operation in
// flight, valid/ready on both sides.
module fdiv_seq
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  // Derived operand width; leave at its default.
  parameter int N     = EXP_W + MAN_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] q,
  output logic [4:0]   flags
);

  localparam int CNT_W = $clog2(MAN_W + 3);
  localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(MAN_W + 2);
  localparam logic signed [EXP_W+1:0] BIAS_X  = (EXP_W + 2)'(bias(EXP_W));
  localparam logic signed [EXP_W+1:0] EMAX    = (EXP_W + 2)'((1 << EXP_W) - 1);
  localparam logic signed [EXP_W+1:0] EXP_ONE = (EXP_W + 2)'(1);
  localparam logic [N-1:0]            QNAN_V  = N'(qnan(EXP_W, MAN_W));

  fdiv_state_e state_reg;

  // Datapath registers
  logic                      sign_reg;
  logic signed [EXP_W+1:0]   exp_reg;
  logic [MAN_W:0]            div_reg;   // divisor with hidden bit
  logic [MAN_W+1:0]          rem_reg;   // partial remainder, always < 2*divisor
  logic [MAN_W+2:0]          quo_reg;   // quotient bits, MSB has weight 1
  logic [CNT_W-1:0]          cnt_reg;   // number of quotient bits produced
  logic [N-1:0]              q_reg;
  logic [4:0]                flags_reg;

  // Operand fields
  fp_class_e        a_cls, b_cls;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W:0]   a_man, b_man;
  logic             sign_in;

  assign a_exp   = a[N-2:MAN_W];
  assign b_exp   = b[N-2:MAN_W];
  assign a_man   = {1'b1, a[MAN_W-1:0]};
  assign b_man   = {1'b1, b[MAN_W-1:0]};
  assign sign_in = a[N-1] ^ b[N-1];

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .mag (a[N-2:0]),
    .cls (a_cls)
  );

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .mag (b[N-2:0]),
    .cls (b_cls)
  );

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign q         = q_reg;
  assign flags     = flags_reg;

  // Special-case resolution, evaluated on the incoming operands.
  logic         is_special;
  logic [N-1:0] spec_q;
  logic [4:0]   spec_flags;
  logic [N-1:0] inf_v, zero_v;

  assign inf_v  = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  assign zero_v = {sign_in, {(N-1){1'b0}}};

  // Priority: NaN, 0/0 or inf/inf, inf/x, x/0, 0/x or x/inf.
  always_comb begin
    is_special = 1'b1;
    spec_q     = '0;
    spec_flags = '0;
    if (a_cls == QNAN || a_cls == SNAN || b_cls == QNAN || b_cls == SNAN) begin
      spec_q                   = QNAN_V;
      spec_flags[FLAG_INVALID] = (a_cls == SNAN) || (b_cls == SNAN);
    end else if ((a_cls == ZERO && b_cls == ZERO) || (a_cls == INF && b_cls == INF)) begin
      spec_q                   = QNAN_V;
      spec_flags[FLAG_INVALID] = 1'b1;
    end else if (a_cls == INF) begin
      spec_q = inf_v;
    end else if (b_cls == ZERO) begin
      spec_q                    = inf_v;
      spec_flags[FLAG_DIV_ZERO] = 1'b1;
    end else if (a_cls == ZERO || b_cls == INF) begin
      spec_q = zero_v;
    end else begin
      is_special = 1'b0;
    end
  end

  // One restoring step. The first step runs on the accept edge straight from
  // the operands, the rest from the registered remainder.
  logic [MAN_W+1:0] rem_src;
  logic [MAN_W:0]   div_src;
  logic [MAN_W+2:0] trial;
  logic [MAN_W+1:0] rem_sel;
  logic [MAN_W+1:0] rem_next;
  logic             qbit;

  always_comb begin
    rem_src  = (state_reg == IDLE) ? {1'b0, a_man} : rem_reg;
    div_src  = (state_reg == IDLE) ? b_man : div_reg;
    trial    = {1'b0, rem_src} - {2'b00, div_src};
    qbit     = ~trial[MAN_W+2];
    rem_sel  = qbit ? trial[MAN_W+1:0] : rem_src;
    rem_next = rem_sel << 1;
  end

  // Normalise, round to nearest even, then range-check the exponent.
  logic                    msb;
  logic [MAN_W:0]          mant;
  logic                    guard, sticky, round_up;
  logic [MAN_W+1:0]        mant_rnd;
  logic signed [EXP_W+1:0] e_norm, e_rnd;
  logic [MAN_W-1:0]        frac;
  logic [N-1:0]            norm_q;
  logic [4:0]              norm_flags;

  always_comb begin
    msb = quo_reg[MAN_W+2];
    if (msb) begin
      mant   = quo_reg[MAN_W+2:2];
      guard  = quo_reg[1];
      sticky = quo_reg[0] | (|rem_reg);
      e_norm = exp_reg;
    end else begin
      mant   = quo_reg[MAN_W+1:1];
      guard  = quo_reg[0];
      sticky = |rem_reg;
      e_norm = exp_reg - EXP_ONE;
    end
    round_up = guard & (sticky | mant[0]);
    mant_rnd = {1'b0, mant} + {{(MAN_W+1){1'b0}}, round_up};
    if (mant_rnd[MAN_W+1]) begin
      frac  = mant_rnd[MAN_W:1];
      e_rnd = e_norm + EXP_ONE;
    end else begin
      frac  = mant_rnd[MAN_W-1:0];
      e_rnd = e_norm;
    end
    norm_flags               = '0;
    norm_flags[FLAG_INEXACT] = guard | sticky;
    if (e_rnd >= EMAX) begin
      norm_q                    = {sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      norm_flags[FLAG_OVERFLOW] = 1'b1;
      norm_flags[FLAG_INEXACT]  = 1'b1;
    end else if (e_rnd <= 0) begin
      norm_q                     = {sign_reg, {(N-1){1'b0}}};
      norm_flags[FLAG_UNDERFLOW] = 1'b1;
      norm_flags[FLAG_INEXACT]   = 1'b1;
    end else begin
      norm_q = {sign_reg, e_rnd[EXP_W-1:0], frac};
    end
  end

  // Sequencer and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sign_reg  <= 1'b0;
      exp_reg   <= '0;
      div_reg   <= '0;
      rem_reg   <= '0;
      quo_reg   <= '0;
      cnt_reg   <= '0;
      q_reg     <= '0;
      flags_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            sign_reg <= sign_in;
            if (is_special) begin
              q_reg     <= spec_q;
              flags_reg <= spec_flags;
              state_reg <= DONE;
            end else begin
              exp_reg   <= {2'b00, a_exp} - {2'b00, b_exp} + BIAS_X;
              div_reg   <= b_man;
              rem_reg   <= rem_next;
              quo_reg   <= {{(MAN_W+2){1'b0}}, qbit};
              cnt_reg   <= CNT_W'(1);
              state_reg <= DIV;
            end
          end
        end
        DIV: begin
          rem_reg <= rem_next;
          quo_reg <= {quo_reg[MAN_W+1:0], qbit};
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_LAST) begin
            state_reg <= NORM;
          end
        end
        NORM: begin
          q_reg     <= norm_q;
          flags_reg <= norm_flags;
          state_reg <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fdiv_seq.sv
// Testbench for fdiv_seq: binary32 instance driven by directed and random
// operands against an exact-arithmetic reference model, plus a binary64
// instance for the wide configuration.
module tb_fdiv_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, q;
  logic [4:0]  flags;

  logic        in_valid64, in_ready64, out_valid64, out_ready64;
  logic [63:0] a64, b64, q64;
  logic [4:0]  flags64;

  fdiv_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .flags     (flags)
  );

  fdiv_seq #(.EXP_W(11), .MAN_W(52)) dut64 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid64),
    .in_ready  (in_ready64),
    .a         (a64),
    .b         (b64),
    .out_valid (out_valid64),
    .out_ready (out_ready64),
    .q         (q64),
    .flags     (flags64)
  );

  int vectors    = 0;
  int miscompares = 0;
  int txn        = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [4:0]  f;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Reference: exact IEEE division with RNE, DAZ/FTZ and the special-case
  // priority list. Returns {flags, result}.
  function automatic logic [68:0] model(input int ew, input int mw,
                                        input logic [63:0] av, input logic [63:0] bv);
    logic [127:0] emax, fmask, fa, fb, ma, mb, num, qq, rm, mant, qn, sbit, infv, res;
    int ea, eb, e;
    logic sgn, guard, sticky, up;
    logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
    logic [4:0] fl;
    emax   = (128'd1 << ew) - 1;
    fmask  = (128'd1 << mw) - 1;
    fa     = {64'd0, av} & fmask;
    fb     = {64'd0, bv} & fmask;
    ea     = int'(({64'd0, av} >> mw) & emax);
    eb     = int'(({64'd0, bv} >> mw) & emax);
    sgn    = av[ew + mw] ^ bv[ew + mw];
    a_nan  = (ea == int'(emax)) && (fa != 0);
    b_nan  = (eb == int'(emax)) && (fb != 0);
    a_snan = a_nan && !fa[mw - 1];
    b_snan = b_nan && !fb[mw - 1];
    a_inf  = (ea == int'(emax)) && (fa == 0);
    b_inf  = (eb == int'(emax)) && (fb == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    qn     = (emax << mw) | (128'd1 << (mw - 1));
    sbit   = {127'd0, sgn} << (ew + mw);
    infv   = sbit | (emax << mw);
    fl     = '0;
    res    = '0;
    if (a_nan || b_nan) begin
      res = qn; fl[4] = a_snan || b_snan;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      res = qn; fl[4] = 1'b1;
    end else if (a_inf) begin
      res = infv;
    end else if (b_zero) begin
      res = infv; fl[3] = 1'b1;
    end else if (a_zero || b_inf) begin
      res = sbit;
    end else begin
      ma = (128'd1 << mw) | fa;
      mb = (128'd1 << mw) | fb;
      e  = ea - eb + ((1 << (ew - 1)) - 1);
      if (ma >= mb) begin
        num = ma << mw;
      end else begin
        num = ma << (mw + 1);
        e   = e - 1;
      end
      qq     = (num << 2) / mb;
      rm     = (num << 2) % mb;
      mant   = qq >> 2;
      guard  = qq[1];
      sticky = qq[0] || (rm != 0);
      up     = guard && (sticky || mant[0]);
      mant   = mant + {127'd0, up};
      if (mant == (128'd1 << (mw + 1))) begin
        mant = mant >> 1;
        e    = e + 1;
      end
      fl[0] = guard || sticky;
      if (e >= int'(emax)) begin
        res = infv; fl[2] = 1'b1; fl[0] = 1'b1;
      end else if (e <= 0) begin
        res = sbit; fl[1] = 1'b1; fl[0] = 1'b1;
      end else begin
        res = sbit | (128'(e) << mw) | (mant & fmask);
      end
    end
    return {fl, res[63:0]};
  endfunction

  function automatic logic [31:0] rand_fp32();
    logic [31:0] r;
    int k;
    r = $urandom();
    k = $urandom_range(0, 15);
    case (k)
      0: r[30:0] = '0;
      1: r[30:0] = {8'hFF, 23'h0};
      2: begin
        r[30:23] = 8'hFF;
        if (r[22:0] == 23'h0) r[0] = 1'b1;
      end
      3: r[30:23] = 8'h00;
      4: r[30:23] = 8'($urandom_range(230, 254));
      5: r[30:23] = 8'($urandom_range(1, 20));
      6: begin
        r[30:23] = 8'($urandom_range(110, 140));
        r[18:0]  = '0;
      end
      7: if (r[30:23] == 8'hFF || r[30:23] == 8'h00) r[30:23] = 8'h7F;
      default: r[30:23] = 8'($urandom_range(100, 154));
    endcase
    return r;
  endfunction

  // Issue one binary32 operation, measure latency (accept edge counts as 1),
  // optionally stall the consumer, then complete the handshake.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                        input int want_lat, input int stall);
    int lat;
    int waitc;
    logic [68:0] m;
    exp_t x;
    waitc = 0;
    while (!in_ready && waitc < 200) begin
      @(posedge clk); #1; waitc++;
    end
    check("in_ready_wait", {63'd0, in_ready}, 64'd1);
    m   = model(8, 23, {32'd0, av}, {32'd0, bv});
    x.a = av; x.b = bv; x.q = m[31:0]; x.f = m[68:64];
    exp_q.push_back(x);
    out_ready = (stall == 0);
    a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    check("result_timeout", {63'd0, out_valid}, 64'd1);
    if (want_lat > 0) check("latency", 64'(lat), 64'(want_lat));
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("stall_valid", {63'd0, out_valid}, 64'd1);
      check("stall_in_ready", {63'd0, in_ready}, 64'd0);
      check("stall_q", {32'd0, q}, {32'd0, x.q});
      check("stall_flags", {59'd0, flags}, {59'd0, x.f});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_hs_in_ready", {63'd0, in_ready}, 64'd1);
    check("post_hs_out_valid", {63'd0, out_valid}, 64'd0);
  endtask

  task automatic run_op64(input logic [63:0] av, input logic [63:0] bv, input int want_lat);
    int lat;
    logic [68:0] m;
    m = model(11, 52, av, bv);
    check("in_ready64", {63'd0, in_ready64}, 64'd1);
    a64 = av; b64 = bv; in_valid64 = 1'b1;
    @(posedge clk); #1;
    in_valid64 = 1'b0;
    lat = 1;
    while (!out_valid64 && lat < 300) begin
      @(posedge clk); #1; lat++;
    end
    check("result_timeout64", {63'd0, out_valid64}, 64'd1);
    if (want_lat > 0) check("latency64", 64'(lat), 64'(want_lat));
    check("q64", q64, m[63:0]);
    check("flags64", {59'd0, flags64}, {59'd0, m[68:64]});
    $display("txn64 a=%h b=%h q=%h flags=%b", av, bv, q64, flags64);
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [68:0] m;
    logic        stale;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    in_valid64 = 1'b0; out_ready64 = 1'b1; a64 = '0; b64 = '0;

    // Compare process: every cycle a binary32 result is presented it must
    // match the oldest outstanding expectation.
    fork
      forever begin
        @(negedge clk);
        if (!rst && out_valid) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL stale_result: got q=%h flags=%b, required no result", q, flags);
          end else if (q !== exp_q[0].q || flags !== exp_q[0].f) begin
            miscompares++;
            $display("FAIL result a=%h b=%h: got q=%h flags=%b, required q=%h flags=%b",
                     exp_q[0].a, exp_q[0].b, q, flags, exp_q[0].q, exp_q[0].f);
          end
        end
      end
      forever begin
        @(posedge clk);
        if (!rst && out_valid && out_ready && exp_q.size() > 0) begin
          txn++;
          $display("txn %0d a=%h b=%h q=%h flags=%b", txn, exp_q[0].a, exp_q[0].b, q, flags);
          void'(exp_q.pop_front());
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_q", {32'd0, q}, 64'd0);
    check("reset_flags", {59'd0, flags}, 64'd0);

    // Hand-computed values that pin the reference model.
    m = model(8, 23, 64'h40C00000, 64'h40000000); check("model_6div2", {27'd0, m[68:64], m[31:0]}, {27'd0, 5'b00000, 32'h40400000});
    m = model(8, 23, 64'h3F800000, 64'h40400000); check("model_1div3", {27'd0, m[68:64], m[31:0]}, {27'd0, 5'b00001, 32'h3EAAAAAB});
    m = model(8, 23, 64'hBF800000, 64'h3F800000); check("model_neg1", {27'd0, m[68:64], m[31:0]}, {27'd0, 5'b00000, 32'hBF800000});
    m = model(8, 23, 64'h3F800000, 64'h00000000); check("model_div0", {27'd0, m[68:64], m[31:0]}, {27'd0, 5'b01000, 32'h7F800000});
    m = model(8, 23, 64'h00000000, 64'h00000000); check("model_0div0", {27'd0, m[68:64], m[31:0]}, {27'd0, 5'b10000, 32'h7FC00000});
    m = model(8, 23, 64'h7F800001, 64'h3F800000); check("model_snan", {27'd0, m[68:64], m[31:0]}, {27'd0, 5'b10000, 32'h7FC00000});
    m = model(8, 23, 64'h7F000000, 64'h00800000); check("model_ovf", {27'd0, m[68:64], m[31:0]}, {27'd0, 5'b00101, 32'h7F800000});
    m = model(8, 23, 64'h00800000, 64'h4B000000); check("model_unf", {27'd0, m[68:64], m[31:0]}, {27'd0, 5'b00011, 32'h00000000});
    m = model(11, 52, 64'h4018000000000000, 64'h4000000000000000);
    check("model64_6div2", m[63:0], 64'h4008000000000000);

    // Directed binary32 operations with latency checks.
    run_op(32'h40C00000, 32'h40000000, 27, 0);
    run_op(32'h3F800000, 32'h40400000, 27, 0);
    run_op(32'hBF800000, 32'h3F800000, 27, 0);
    run_op(32'h3F800000, 32'h00000000, 1, 0);
    run_op(32'h00000000, 32'h00000000, 1, 0);
    run_op(32'h7F800001, 32'h3F800000, 1, 0);
    run_op(32'h7F000000, 32'h00800000, 27, 0);
    run_op(32'h00800000, 32'h4B000000, 27, 0);
    run_op(32'hFF800000, 32'h3F800000, 1, 0);
    run_op(32'h7FC00000, 32'h7F800000, 1, 0);
    run_op(32'h00000001, 32'hC0000000, 1, 0);

    // Consumer back-pressure for five cycles in DONE.
    run_op(32'h3F800000, 32'h40400000, 27, 5);

    // Reset in the middle of a division: the operation is dropped.
    out_ready = 1'b1;
    check("pre_rst_in_ready", {63'd0, in_ready}, 64'd1);
    a = 32'h40490FDB; b = 32'h402DF854;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    stale = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) stale = 1'b1;
    end
    check("mid_rst_no_result", {63'd0, stale}, 64'd0);

    // Randomised binary32 traffic with occasional consumer stalls.
    for (int i = 0; i < 300; i++) begin
      run_op(rand_fp32(), rand_fp32(), 0, ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
    end

    // binary64 configuration.
    run_op64(64'h4018000000000000, 64'h4000000000000000, 56);
    run_op64(64'h3FF0000000000000, 64'h4008000000000000, 56);
    run_op64(64'h3FF0000000000000, 64'h0000000000000000, 1);
    for (int i = 0; i < 20; i++) begin
      logic [63:0] ra, rb;
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      ra[62:52] = 11'($urandom_range(900, 1150));
      rb[62:52] = 11'($urandom_range(900, 1150));
      run_op64(ra, rb, 56);
    end

    repeat (5) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fdiv_seq.md
Name: fdiv_seq

Overview:
- Multi-cycle IEEE-754 binary floating-point divider, parametrised in exponent and mantissa width; defaults give binary32, and EXP_W=11 / MAN_W=52 gives binary64.
- Radix-2 restoring mantissa division, one quotient bit per cycle, with round-to-nearest-even.
- Full special-value handling and an exception flag vector.
- Sits on the FP datapath behind a valid/ready handshake, one operation in flight at a time.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored mantissa field width (hidden bit excluded)
N, EXP_W+MAN_W+1, operand/result width (derived; must not be overridden)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operands valid
in_ready  out  1  block can accept operands
a  in  N  dividend
b  in  N  divisor
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
q  out  N  quotient
flags  out  5  {invalid, div_by_zero, overflow, underflow, inexact}

Behaviour:
- Reset: state=IDLE; in_ready=1; out_valid=0; q=0; flags=0; all datapath registers cleared. Reset mid-operation abandons the operation, and no result is produced.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, register a and b and classify them. Any special case goes to DONE next cycle; otherwise go to DIV.
  - DIV: iteration counter runs 0..MAN_W+2, giving MAN_W+3 quotient bits: hidden bit, MAN_W mantissa bits, guard bit, plus one extra bit for the normalise shift. Each cycle: r=2r-d; if r>=0 keep r and set q bit to 1, else restore and set q bit to 0. At count MAN_W+2, go to NORM.
  - NORM: normalise, round, detect overflow/underflow, form q and flags, then go to DONE.
  - DONE: out_valid=1. q and flags hold stable until out_valid&out_ready, then return to IDLE with in_ready=1 on the following cycle. There is no same-cycle accept in DONE.
- Latency from the accept edge: normal operands give out_valid after MAN_W+4 edges (27 for binary32); special cases give out_valid after 1 edge.
- Sign: q sign = a sign XOR b sign, including zero and inf results. NaN output is always the canonical quiet NaN with sign 0: exponent all ones, mantissa MSB set, remaining bits zero.
- Subnormal inputs are treated as signed zero (DAZ). Subnormal results flush to signed zero (FTZ) and set underflow and inexact.
- Special-case priority, highest first:
  1. Either operand NaN → qNaN; invalid=1 only if an input is a signalling NaN.
  2. 0/0 or inf/inf → qNaN, invalid=1.
  3. inf/x → inf.
  4. x/0 (x finite, nonzero) → inf, div_by_zero=1.
  5. 0/x or x/inf → zero.
- Exponent path:
  - e = ea - eb + BIAS, computed in EXP_W+2-bit signed arithmetic, where BIAS = 2^(EXP_W-1)-1.
  - Mantissa quotient lies in (0.5, 2). If the quotient MSB is 0, shift left 1 and decrement e.
- Rounding: guard = next quotient bit; sticky = (remainder != 0). Round up when guard & (sticky | lsb).
  - A mantissa carry-out renormalises and increments e.
  - inexact = guard | sticky.
- After rounding:
  - e >= 2^EXP_W - 1 → inf, overflow=1, inexact=1.
  - e <= 0 → signed zero, underflow=1, inexact=1.
- in_valid while in_ready=0 is ignored; the producer holds its operands.

Decomposition:
- fp_pkg holds:
  - the fp_class_e enum {ZERO, NORMAL, INF, QNAN, SNAN}
  - the flag bit-index constants
  - the fdiv_state_e enum {IDLE, DIV, NORM, DONE}
  - functions bias(EXP_W) and qnan(EXP_W, MAN_W)
- Sub-module fp_classify (parametrised EXP_W, MAN_W) is instantiated twice, once for a and once for b.
- The divider core, rounding and FSM stay in fdiv_seq.

Test Plan:
- 0x40C00000 / 0x40000000 (6.0/2.0) → q=0x40400000, flags=0, out_valid exactly 27 cycles after accept.
- 0x3F800000 / 0x40400000 (1/3) → q=0x3EAAAAAB, inexact=1; 0xBF800000 / 0x3F800000 → q=0xBF800000, flags=0.
- 0x3F800000 / 0x00000000 → q=0x7F800000, div_by_zero=1. 0x00000000 / 0x00000000 → q=0x7FC00000, invalid=1. 0x7F800001 / 0x3F800000 → q=0x7FC00000, invalid=1. All three give out_valid after 1 cycle.
- 0x7F000000 / 0x00800000 → q=0x7F800000, overflow=1, inexact=1. 0x00800000 / 0x4B000000 → q=0x00000000, underflow=1, inexact=1.
- Back-pressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE → q and flags stable, in_ready=0.
  - Assert rst at DIV count 10 → in_ready=1 and out_valid=0 next cycle, and no stale result ever appears.
- EXP_W=11, MAN_W=52: 0x4018000000000000 / 0x4000000000000000 → 0x4008000000000000, latency 56 cycles.
